// File: rtl/ram_wait_param_if.sv
// rtl/ram_wait_param_if.sv - memory-mapped bus between a master and the wait-state RAM
interface ram_wait_param_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        err;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, err
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, err
  );
endinterface

// File: rtl/ram_wait_param.sv
// rtl/ram_wait_param.sv - word RAM with fixed or pseudo-random wait states and sticky error flag
module ram_wait_param #(
  parameter              RAM_INIT_FILE = "",
  parameter logic [31:0] ADDR_BASE     = 32'hBFC00000,
  parameter int          DEPTH_LOG2    = 16,
  parameter int          WAIT_MODE     = 1,
  parameter int          WAIT_CYCLES   = 2,
  parameter int          RAND_BITS     = 3,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic          clk,
  input  logic          reset,
  ram_wait_param_if.slave bus
);
  localparam int          DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] RAND_MASK = 16'((32'd1 << RAND_BITS) - 32'd1);

  typedef enum logic {IDLE, STALL} state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [15:0] r_lfsr;
  logic        r_err;
  logic [31:0] r_rdata;
  logic [31:0] r_addr;
  logic        r_rd;
  logic        r_wr;
  logic [31:0] r_mem [DEPTH];

  logic                  w_req;
  logic                  w_halt;
  logic [15:0]           w_n;
  logic                  w_same;
  logic                  w_accept;
  logic                  w_abort;
  logic [31:0]           w_off;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_in_range;
  logic                  w_be_ok;
  logic                  w_bad;
  logic [31:0]           w_mask;
  logic [15:0]           w_lfsr_next;

  // Memory image at time zero: zero everywhere
  initial begin
    for (int i = 0; i < DEPTH; i++) r_mem[i] = 32'd0;
  end

  // Request decode, stall length, acceptance and access legality
  always_comb begin
    w_req    = bus.read | bus.write;
    w_halt   = (bus.address == 32'd0);
    w_n      = 16'd0;
    if (!w_halt) begin
      if (WAIT_MODE == 1)      w_n = 16'(WAIT_CYCLES);
      else if (WAIT_MODE == 2) w_n = r_lfsr & RAND_MASK;
    end
    w_same   = w_req && (bus.address == r_addr) && (bus.read == r_rd) && (bus.write == r_wr);
    w_accept = !reset && w_req &&
               (((r_state == IDLE) && (w_n == 16'd0)) ||
                ((r_state == STALL) && (r_cnt == 16'd1) && w_same));
    w_abort  = !reset && (r_state == STALL) && !w_same;

    w_off      = bus.address - ADDR_BASE;
    w_idx      = w_off[DEPTH_LOG2+1:2];
    w_in_range = (bus.address >= ADDR_BASE) && ((w_off >> (DEPTH_LOG2 + 2)) == 32'd0);
    case (bus.byteenable)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b0110, 4'b1100, 4'b0111, 4'b1110, 4'b1111: w_be_ok = 1'b1;
      default:                                              w_be_ok = 1'b0;
    endcase
    // The halt address is always a harmless no-op, never an error
    w_bad  = !w_halt && ((bus.read && bus.write) || !w_be_ok ||
                         (bus.address[1:0] != 2'b00) || !w_in_range);
    w_mask = {{8{bus.byteenable[3]}}, {8{bus.byteenable[2]}},
              {8{bus.byteenable[1]}}, {8{bus.byteenable[0]}}};
    w_lfsr_next = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
  end

  // Stall FSM, LFSR stepping per accepted transaction, and sticky error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 16'd0;
      r_lfsr  <= SEED;
      r_err   <= 1'b0;
      r_addr  <= 32'd0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req && !w_accept) begin
            r_state <= STALL;
            r_cnt   <= w_n;
            r_addr  <= bus.address;
            r_rd    <= bus.read;
            r_wr    <= bus.write;
          end
        end
        STALL: begin
          if (w_abort) begin
            r_state <= IDLE;
            r_cnt   <= 16'd0;
            r_err   <= 1'b1;
          end else if (w_accept) begin
            r_state <= IDLE;
            r_cnt   <= 16'd0;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_accept) r_lfsr <= w_lfsr_next;
      if (w_accept && w_bad) r_err <= 1'b1;
    end
  end

  // Read data register: masked word on a good read, zero on halt or error reads
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= 32'd0;
    end else if (w_accept && bus.read) begin
      r_rdata <= (w_halt || w_bad) ? 32'd0 : (r_mem[w_idx] & w_mask);
    end
  end

  // Byte-lane memory write; contents are deliberately untouched by reset
  always_ff @(posedge clk) begin
    if (w_accept && bus.write && !w_halt && !w_bad) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.byteenable[b]) r_mem[w_idx][8*b +: 8] <= bus.writedata[8*b +: 8];
      end
    end
  end

  assign bus.waitrequest = !w_accept;
  assign bus.readdata    = r_rdata;
  assign bus.err         = r_err;
endmodule

// File: tb/tb_ram_wait_param.sv
// tb/tb_ram_wait_param.sv - directed vector bench for ram_wait_param in fixed and random stall modes
module tb_ram_wait_param;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_wait_param_if b1();
  ram_wait_param_if b2();

  ram_wait_param #(.WAIT_MODE(1), .WAIT_CYCLES(2), .DEPTH_LOG2(10)) u1 (
    .clk(clk), .reset(rst), .bus(b1)
  );
  ram_wait_param #(.WAIT_MODE(2), .RAND_BITS(3), .DEPTH_LOG2(10), .LFSR_SEED(16'hACE1)) u2 (
    .clk(clk), .reset(rst), .bus(b2)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        pre_rst;
    logic [31:0] a;
    logic        rd;
    logic        wr;
    logic [31:0] wd;
    logic [3:0]  be;
    int          waits;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic [31:0] a, input logic rd, input logic wr,
                       input logic [31:0] wd, input logic [3:0] be);
    if (sel == 0) begin
      b1.address = a; b1.read = rd; b1.write = wr; b1.writedata = wd; b1.byteenable = be;
    end else begin
      b2.address = a; b2.read = rd; b2.write = wr; b2.writedata = wd; b2.byteenable = be;
    end
  endtask

  function automatic logic get_wait(input int sel);
    return (sel == 0) ? b1.waitrequest : b2.waitrequest;
  endfunction

  function automatic logic [31:0] get_rdata(input int sel);
    return (sel == 0) ? b1.readdata : b2.readdata;
  endfunction

  function automatic logic get_err(input int sel);
    return (sel == 0) ? b1.err : b2.err;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic fb;
    fb = v[0] ^ v[2] ^ v[3] ^ v[5];
    return {fb, v[15:1]};
  endfunction

  function automatic logic [31:0] data_of(input int i);
    return 32'h5A000000 + 32'(i) * 32'h01020304;
  endfunction

  task automatic idle(input int sel);
    drive(sel, 32'd0, 1'b0, 1'b0, 32'd0, 4'd0);
  endtask

  // Called just after a rising edge; returns just after the acceptance edge with the request still driven
  task automatic xact(input int sel, input logic [31:0] a, input logic rd, input logic wr,
                      input logic [31:0] wd, input logic [3:0] be,
                      output int waits, output logic [31:0] rd_first);
    drive(sel, a, rd, wr, wd, be);
    waits = 0;
    @(negedge clk);
    rd_first = get_rdata(sel);
    while (get_wait(sel)) begin
      waits++;
      if (waits > 40) begin
        total++;
        bad++;
        $display("FAIL timeout: waitrequest stuck high at %h", a);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(0);
    idle(1);
    @(negedge clk);
    chk("wait_in_reset", 32'(b1.waitrequest), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rdata_after_reset", b1.readdata, 32'd0);
    chk("err_after_reset", 32'(b1.err), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int          w;
    logic [31:0] rf;
    logic [15:0] m;

    vecs.push_back('{0, 32'hBFC00010, 1, 0, 32'h0,        4'hF,    2, 32'h0,        0}); // unused slot replaced below
    vecs.delete();
    vecs.push_back('{0, 32'hBFC00010, 0, 1, 32'h12345678, 4'hF,    2, 32'h0,        0});
    vecs.push_back('{0, 32'hBFC00010, 1, 0, 32'h0,        4'hF,    2, 32'h12345678, 0});
    vecs.push_back('{0, 32'hBFC00010, 0, 1, 32'hFFFFAAAA, 4'b0011, 2, 32'h0,        0});
    vecs.push_back('{0, 32'hBFC00010, 1, 0, 32'h0,        4'hF,    2, 32'h1234AAAA, 0});
    vecs.push_back('{0, 32'hBFC00010, 1, 0, 32'h0,        4'b1100, 2, 32'h12340000, 0});
    vecs.push_back('{0, 32'hBFC00010, 1, 0, 32'h0,        4'b0000, 2, 32'h0,        0});
    vecs.push_back('{0, 32'h00000000, 1, 0, 32'h0,        4'hF,    0, 32'h0,        0});
    vecs.push_back('{0, 32'h00000000, 0, 1, 32'hDEADBEEF, 4'hF,    0, 32'h0,        0});
    vecs.push_back('{0, 32'hBFC00FFC, 0, 1, 32'hCAFEF00D, 4'hF,    2, 32'h0,        0});
    vecs.push_back('{0, 32'hBFC00FFC, 1, 0, 32'h0,        4'hF,    2, 32'hCAFEF00D, 0});
    vecs.push_back('{0, 32'hBFC00010, 0, 1, 32'hFFFFFFFF, 4'b1010, 2, 32'h0,        1});
    vecs.push_back('{0, 32'hBFC00010, 1, 0, 32'h0,        4'hF,    2, 32'h1234AAAA, 1});
    vecs.push_back('{1, 32'hBFC01000, 1, 0, 32'h0,        4'hF,    2, 32'h0,        1});
    vecs.push_back('{1, 32'hBFC00012, 1, 0, 32'h0,        4'hF,    2, 32'h0,        1});
    vecs.push_back('{1, 32'hBFBFFFFC, 1, 0, 32'h0,        4'hF,    2, 32'h0,        1});
    vecs.push_back('{1, 32'hBFC00010, 1, 1, 32'h0,        4'hF,    2, 32'h0,        1});
    vecs.push_back('{1, 32'hBFC00010, 1, 0, 32'h0,        4'hF,    2, 32'h1234AAAA, 0});

    do_reset();

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].pre_rst) do_reset();
      xact(0, vecs[i].a, vecs[i].rd, vecs[i].wr, vecs[i].wd, vecs[i].be, w, rf);
      chk($sformatf("v%0d_waits", i), 32'(w), 32'(vecs[i].waits));
      idle(0);
      @(negedge clk);
      if (vecs[i].rd) chk($sformatf("v%0d_rdata", i), b1.readdata, vecs[i].rdata);
      chk($sformatf("v%0d_err", i), 32'(b1.err), 32'(vecs[i].err));
      @(posedge clk); #1;
    end

    // Read dropped after one stall cycle sets err
    do_reset();
    drive(0, 32'hBFC00010, 1'b1, 1'b0, 32'd0, 4'hF);
    @(negedge clk);
    chk("drop_wait", 32'(b1.waitrequest), 32'd1);
    @(posedge clk); #1;
    idle(0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drop_err", 32'(b1.err), 32'd1);
    @(posedge clk); #1;

    // Reset in the middle of a write stall: no write, flags cleared
    drive(0, 32'hBFC00010, 1'b0, 1'b1, 32'h0, 4'hF);
    @(negedge clk);
    chk("rststall_wait", 32'(b1.waitrequest), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rststall_wait_rst", 32'(b1.waitrequest), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(0);
    @(negedge clk);
    chk("rststall_err", 32'(b1.err), 32'd0);
    chk("rststall_rdata", b1.readdata, 32'd0);
    @(posedge clk); #1;
    xact(0, 32'hBFC00010, 1'b1, 1'b0, 32'd0, 4'hF, w, rf);
    idle(0);
    @(negedge clk);
    chk("rststall_word", b1.readdata, 32'h1234AAAA);
    @(posedge clk); #1;

    // readdata holds across a later write and idle cycles
    xact(0, 32'hBFC00FFC, 1'b0, 1'b1, 32'h11111111, 4'hF, w, rf);
    idle(0);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rdata_hold", b1.readdata, 32'h1234AAAA);
    chk("hold_err", 32'(b1.err), 32'd0);
    @(posedge clk); #1;

    // Address change mid-stall aborts with err
    drive(0, 32'hBFC00010, 1'b1, 1'b0, 32'd0, 4'hF);
    @(posedge clk); #1;
    drive(0, 32'hBFC00014, 1'b1, 1'b0, 32'd0, 4'hF);
    @(posedge clk); #1;
    idle(0);
    @(negedge clk);
    chk("addr_change_err", 32'(b1.err), 32'd1);
    @(posedge clk); #1;

    // Pseudo-random stalls: preload 20 words, then 20 back-to-back reads
    do_reset();
    m = 16'hACE1;
    for (int i = 0; i < 20; i++) begin
      xact(1, 32'hBFC00000 + 32'(i) * 4, 1'b0, 1'b1, data_of(i), 4'hF, w, rf);
      chk($sformatf("m2_wr%0d_waits", i), 32'(w), 32'(m[2:0]));
      m = lfsr_step(m);
    end
    for (int i = 0; i < 20; i++) begin
      xact(1, 32'hBFC00000 + 32'(i) * 4, 1'b1, 1'b0, 32'd0, 4'hF, w, rf);
      chk($sformatf("m2_rd%0d_waits", i), 32'(w), 32'(m[2:0]));
      if (i > 0) chk($sformatf("m2_rd%0d_data", i - 1), rf, data_of(i - 1));
      m = lfsr_step(m);
    end
    idle(1);
    @(negedge clk);
    chk("m2_rd19_data", b2.readdata, data_of(19));
    chk("m2_err", 32'(get_err(1)), 32'd0);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
